// File: rtl/mem_pkg.sv
// Shared definitions for the memory handshake stage: op codes, FSM states,
// access sizes and the op-code decoder.
package mem_pkg;

  localparam int BE_W = 4;

  localparam logic [5:0] OP_LB  = 6'b100001;
  localparam logic [5:0] OP_LH  = 6'b101011;
  localparam logic [5:0] OP_LBU = 6'b101010;
  localparam logic [5:0] OP_LHU = 6'b101100;
  localparam logic [5:0] OP_LW  = 6'b111101;
  localparam logic [5:0] OP_LL  = 6'b101000;
  localparam logic [5:0] OP_SB  = 6'b101111;
  localparam logic [5:0] OP_SH  = 6'b110000;
  localparam logic [5:0] OP_SW  = 6'b110001;
  localparam logic [5:0] OP_SC  = 6'b110110;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_t;

  typedef struct packed {
    logic  is_load;
    logic  is_store;
    logic  is_ll;
    logic  is_sc;
    logic  sext;
    size_t size;
  } mem_op_t;

  // Anything not listed decodes as a non-memory op (no load, no store).
  function automatic mem_op_t decode_op(input logic [5:0] code);
    mem_op_t d;
    d = '{is_load: 1'b0, is_store: 1'b0, is_ll: 1'b0, is_sc: 1'b0, sext: 1'b0, size: SZ_WORD};
    case (code)
      OP_LB:   begin d.is_load = 1'b1; d.sext = 1'b1; d.size = SZ_BYTE; end
      OP_LH:   begin d.is_load = 1'b1; d.sext = 1'b1; d.size = SZ_HALF; end
      OP_LBU:  begin d.is_load = 1'b1; d.size = SZ_BYTE; end
      OP_LHU:  begin d.is_load = 1'b1; d.size = SZ_HALF; end
      OP_LW:   d.is_load = 1'b1;
      OP_LL:   begin d.is_load = 1'b1; d.is_ll = 1'b1; end
      OP_SB:   begin d.is_store = 1'b1; d.size = SZ_BYTE; end
      OP_SH:   begin d.is_store = 1'b1; d.size = SZ_HALF; end
      OP_SW:   d.is_store = 1'b1;
      OP_SC:   begin d.is_store = 1'b1; d.is_sc = 1'b1; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic misaligned(input size_t size, input logic [1:0] off);
    case (size)
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the pipeline and a 32-bit word-addressed memory:
// store replication, byte enables and load extraction with sign handling.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  size_t            size_i,
  input  logic             sext_i,
  input  logic             is_store_i,
  input  logic [1:0]       offset_i,
  input  logic [31:0]      st_data_i,
  input  logic [31:0]      rdata_i,
  output logic [BE_W-1:0]  be_o,
  output logic [31:0]      wdata_o,
  output logic [31:0]      ld_data_o
);

  logic [1:0]  byte_pos;
  logic        half_pos;
  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Lane position counts from the LSB of the word; big-endian mirrors the offset.
  always_comb begin
    byte_pos   = BIG_ENDIAN ? ~offset_i : offset_i;
    half_pos   = BIG_ENDIAN ? ~offset_i[1] : offset_i[1];
    byte_shift = rdata_i >> {byte_pos, 3'b000};
    half_shift = rdata_i >> {half_pos, 4'b0000};
    ld_byte    = byte_shift[7:0];
    ld_half    = half_shift[15:0];
    wdata_o    = st_data_i;
    ld_data_o  = rdata_i;
    be_o       = 4'b1111;
    case (size_i)
      SZ_BYTE: begin
        wdata_o   = {4{st_data_i[7:0]}};
        ld_data_o = {{24{sext_i & ld_byte[7]}}, ld_byte};
        if (is_store_i) be_o = 4'b0001 << byte_pos;
      end
      SZ_HALF: begin
        wdata_o   = {2{st_data_i[15:0]}};
        ld_data_o = {{16{sext_i & ld_half[15]}}, ld_half};
        if (is_store_i) be_o = 4'b0011 << {half_pos, 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_handshake.sv
// Memory stage with a req/ack data-memory handshake, upstream stall, address
// and bus-timeout errors, and an optional LL/SC link register.
//
// state  | meaning
// S_IDLE | no access outstanding; a valid memory op issues this cycle
// S_WAIT | request held on the bus, waiting for dm_ack_IN or timeout
module mem_handshake
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int TIMEOUT    = 255,
  parameter bit LLSC_EN    = 1'b1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            Valid_IN,
  input  logic [31:0]     Instr1_PC_IN,
  input  logic [31:0]     ALU_result1_IN,
  input  logic [4:0]      WriteRegister1_IN,
  input  logic [31:0]     MemWriteData1_IN,
  input  logic            RegWrite1_IN,
  input  logic [5:0]      ALU_Control1_IN,
  input  logic            MemRead1_IN,
  input  logic            MemWrite1_IN,
  output logic [4:0]      WriteRegister1_OUT,
  output logic            RegWrite1_OUT,
  output logic [31:0]     WriteData1_OUT,
  output logic [31:0]     Instr1_PC_OUT,
  output logic            Stall_OUT,
  output logic            AddrErr_OUT,
  output logic            BusErr_OUT,
  output logic            dm_req_OUT,
  output logic            dm_we_OUT,
  output logic [31:0]     dm_addr_OUT,
  output logic [BE_W-1:0] dm_be_OUT,
  output logic [31:0]     dm_wdata_OUT,
  input  logic            dm_ack_IN,
  input  logic [31:0]     dm_rdata_IN
);

  // Counter value seen during the last WAIT cycle before a timeout.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            link_valid_q, link_valid_d;
  logic [29:0]     link_addr_q, link_addr_d;
  logic [4:0]      wr_reg_q, wr_reg_d;
  logic            rw_q, rw_d;
  logic [31:0]     wd_q, wd_d;
  logic [31:0]     pc_q, pc_d;
  logic            aerr_q, aerr_d;
  logic            berr_q, berr_d;

  mem_op_t         op;
  logic            is_mem, misal, link_hit, sc_ok, issue, in_wait;
  logic            active, tmo, done, retire;
  logic [BE_W-1:0] be;
  logic [31:0]     st_data, ld_data;

  mem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .size_i     (op.size),
    .sext_i     (op.sext),
    .is_store_i (op.is_store),
    .offset_i   (ALU_result1_IN[1:0]),
    .st_data_i  (MemWriteData1_IN),
    .rdata_i    (dm_rdata_IN),
    .be_o       (be),
    .wdata_o    (st_data),
    .ld_data_o  (ld_data)
  );

  // Op qualification, handshake status and timeout detection; the decoder's
  // read/write strobes gate the op code so a half-decoded op never hits the bus.
  always_comb begin
    op       = decode_op(ALU_Control1_IN);
    is_mem   = Valid_IN & ((op.is_load & MemRead1_IN) | (op.is_store & MemWrite1_IN));
    misal    = misaligned(op.size, ALU_result1_IN[1:0]);
    link_hit = link_valid_q & (link_addr_q == ALU_result1_IN[31:2]);
    sc_ok    = ~(LLSC_EN & op.is_sc) | link_hit;
    in_wait  = (state_q == S_WAIT);
    issue    = ~in_wait & is_mem & ~misal & sc_ok;
    active   = ~RESET & (issue | in_wait);
    tmo      = ~RESET & in_wait & ~dm_ack_IN & (cnt_q == TO_LAST);
    done     = active & dm_ack_IN;
    retire   = done | tmo | (~in_wait & is_mem & ~issue);
  end

  assign dm_req_OUT   = active;
  assign dm_we_OUT    = active & op.is_store;
  assign dm_addr_OUT  = {ALU_result1_IN[31:2], 2'b00};
  assign dm_be_OUT    = be;
  assign dm_wdata_OUT = st_data;
  assign Stall_OUT    = active & ~dm_ack_IN & ~tmo;

  // Next state and timeout count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (issue) begin
        cnt_d = '0;
        if (!dm_ack_IN) state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (dm_ack_IN || tmo) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Writeback: completed accesses, immediate results, and one-cycle error pulses.
  always_comb begin
    wr_reg_d = wr_reg_q;
    wd_d     = wd_q;
    pc_d     = pc_q;
    rw_d     = 1'b0;
    aerr_d   = 1'b0;
    berr_d   = 1'b0;
    if (done) begin
      wr_reg_d = WriteRegister1_IN;
      pc_d     = Instr1_PC_IN;
      rw_d     = RegWrite1_IN;
      wd_d     = op.is_load ? ld_data : (op.is_sc ? 32'd1 : ALU_result1_IN);
    end else if (tmo) begin
      berr_d = 1'b1;
    end else if (!in_wait && Valid_IN) begin
      wr_reg_d = WriteRegister1_IN;
      pc_d     = Instr1_PC_IN;
      if (!is_mem) begin
        wd_d = ALU_result1_IN;
        rw_d = RegWrite1_IN;
      end else if (misal) begin
        aerr_d = 1'b1;
      end else if (!sc_ok) begin
        wd_d = 32'd0;
        rw_d = RegWrite1_IN;
      end
    end
  end

  // Link register: set by a completed LL, cleared by any SC or a store to the linked word.
  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (LLSC_EN) begin
      if (retire && op.is_sc) link_valid_d = 1'b0;
      if (done && op.is_store && link_hit) link_valid_d = 1'b0;
      if (done && op.is_ll) begin
        link_valid_d = 1'b1;
        link_addr_d  = ALU_result1_IN[31:2];
      end
    end
  end

  // FSM state, timeout counter and link register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  // Registered pipeline outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_reg_q <= '0;
      rw_q     <= 1'b0;
      wd_q     <= '0;
      pc_q     <= '0;
      aerr_q   <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      wr_reg_q <= wr_reg_d;
      rw_q     <= rw_d;
      wd_q     <= wd_d;
      pc_q     <= pc_d;
      aerr_q   <= aerr_d;
      berr_q   <= berr_d;
    end
  end

  assign WriteRegister1_OUT = wr_reg_q;
  assign RegWrite1_OUT      = rw_q;
  assign WriteData1_OUT     = wd_q;
  assign Instr1_PC_OUT      = pc_q;
  assign AddrErr_OUT        = aerr_q;
  assign BusErr_OUT         = berr_q;

endmodule

// File: tb/tb_mem_handshake.sv
// Directed bench for mem_handshake: a big-endian LL/SC instance (dut_a) and a
// little-endian instance without LL/SC (dut_b), both with a 4-cycle timeout.
module tb_mem_handshake;
  import mem_pkg::*;

  logic        clk, rst, valid, rwi, mrd, mwr, ack;
  logic [31:0] pc, alu, sdata, rd_a, rd_b;
  logic [4:0]  wr;
  logic [5:0]  opc;

  logic [4:0]  wr_a, wr_b;
  logic        rw_a, rw_b, stall_a, stall_b, aerr_a, aerr_b, berr_a, berr_b;
  logic        req_a, req_b, we_a, we_b;
  logic [31:0] wd_a, wd_b, pco_a, pco_b, addr_a, addr_b, wdat_a, wdat_b;
  logic [3:0]  be_a, be_b;

  int n_chk = 0;
  int n_fail = 0;

  mem_handshake #(.BIG_ENDIAN(1'b1), .TIMEOUT(4), .LLSC_EN(1'b1)) dut_a (
    .CLK(clk), .RESET(rst), .Valid_IN(valid), .Instr1_PC_IN(pc), .ALU_result1_IN(alu),
    .WriteRegister1_IN(wr), .MemWriteData1_IN(sdata), .RegWrite1_IN(rwi),
    .ALU_Control1_IN(opc), .MemRead1_IN(mrd), .MemWrite1_IN(mwr),
    .WriteRegister1_OUT(wr_a), .RegWrite1_OUT(rw_a), .WriteData1_OUT(wd_a),
    .Instr1_PC_OUT(pco_a), .Stall_OUT(stall_a), .AddrErr_OUT(aerr_a), .BusErr_OUT(berr_a),
    .dm_req_OUT(req_a), .dm_we_OUT(we_a), .dm_addr_OUT(addr_a), .dm_be_OUT(be_a),
    .dm_wdata_OUT(wdat_a), .dm_ack_IN(ack), .dm_rdata_IN(rd_a));

  mem_handshake #(.BIG_ENDIAN(1'b0), .TIMEOUT(4), .LLSC_EN(1'b0)) dut_b (
    .CLK(clk), .RESET(rst), .Valid_IN(valid), .Instr1_PC_IN(pc), .ALU_result1_IN(alu),
    .WriteRegister1_IN(wr), .MemWriteData1_IN(sdata), .RegWrite1_IN(rwi),
    .ALU_Control1_IN(opc), .MemRead1_IN(mrd), .MemWrite1_IN(mwr),
    .WriteRegister1_OUT(wr_b), .RegWrite1_OUT(rw_b), .WriteData1_OUT(wd_b),
    .Instr1_PC_OUT(pco_b), .Stall_OUT(stall_b), .AddrErr_OUT(aerr_b), .BusErr_OUT(berr_b),
    .dm_req_OUT(req_b), .dm_we_OUT(we_b), .dm_addr_OUT(addr_b), .dm_be_OUT(be_b),
    .dm_wdata_OUT(wdat_b), .dm_ack_IN(ack), .dm_rdata_IN(rd_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        rw_in;
    logic        exp_req;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdat;
    logic        chk_wd;
    logic [31:0] exp_wd;
    logic        exp_rw;
    logic        exp_ae;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic v, input logic [5:0] o, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rd, input logic rwin,
                              input logic req, input logic we, input logic [3:0] be,
                              input logic [31:0] wdat, input logic cwd, input logic [31:0] wd,
                              input logic rw, input logic ae);
    vec_t t;
    t.valid = v; t.op = o; t.addr = a; t.sdata = sd; t.rdata = rd; t.rw_in = rwin;
    t.exp_req = req; t.exp_we = we; t.exp_be = be; t.exp_wdat = wdat;
    t.chk_wd = cwd; t.exp_wd = wd; t.exp_rw = rw; t.exp_ae = ae;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] o, input logic [31:0] a,
                       input logic [31:0] sd, input logic rwin, input logic [31:0] rd);
    valid = v; opc = o; alu = a; sdata = sd; rwi = rwin; rd_a = rd; rd_b = rd;
    pc = 32'h4000_0000 | a;
    wr = 5'd9;
    mrd = (o == OP_LB) || (o == OP_LH) || (o == OP_LBU) || (o == OP_LHU) ||
          (o == OP_LW) || (o == OP_LL);
    mwr = (o == OP_SB) || (o == OP_SH) || (o == OP_SW) || (o == OP_SC);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   nst;

    vecs[0]  = mk(1, 6'b000000, 32'h1234_5678, 0, 0, 1,           0, 0, 4'h0, 0, 1, 32'h1234_5678, 1, 0);
    vecs[1]  = mk(1, OP_LW,  32'h100, 0, 32'hDEAD_BEEF, 1,        1, 0, 4'hF, 0, 1, 32'hDEAD_BEEF, 1, 0);
    vecs[2]  = mk(1, OP_LB,  32'h103, 0, 32'h0000_00F0, 1,        1, 0, 4'hF, 0, 1, 32'hFFFF_FFF0, 1, 0);
    vecs[3]  = mk(1, OP_LBU, 32'h101, 0, 32'h12F4_5678, 1,        1, 0, 4'hF, 0, 1, 32'h0000_00F4, 1, 0);
    vecs[4]  = mk(1, OP_LH,  32'h102, 0, 32'h1234_8001, 1,        1, 0, 4'hF, 0, 1, 32'hFFFF_8001, 1, 0);
    vecs[5]  = mk(1, OP_LHU, 32'h100, 0, 32'h8001_1234, 1,        1, 0, 4'hF, 0, 1, 32'h0000_8001, 1, 0);
    vecs[6]  = mk(1, OP_SB,  32'h101, 32'h0000_00A5, 0, 0,        1, 1, 4'b0100, 32'hA5A5_A5A5, 0, 0, 0, 0);
    vecs[7]  = mk(1, OP_SH,  32'h202, 32'h1234_ABCD, 0, 0,        1, 1, 4'b0011, 32'hABCD_ABCD, 0, 0, 0, 0);
    vecs[8]  = mk(1, OP_SW,  32'h204, 32'hCAFE_F00D, 0, 0,        1, 1, 4'hF, 32'hCAFE_F00D, 0, 0, 0, 0);
    vecs[9]  = mk(1, OP_LW,  32'h101, 0, 32'h1111_1111, 1,        0, 0, 4'h0, 0, 0, 0, 0, 1);
    vecs[10] = mk(1, OP_SB,  32'h103, 32'h0000_005A, 0, 0,        1, 1, 4'b0001, 32'h5A5A_5A5A, 0, 0, 0, 0);
    vecs[11] = mk(1, OP_LHU, 32'h103, 0, 32'h2222_2222, 1,        0, 0, 4'h0, 0, 0, 0, 0, 1);
    vecs[12] = mk(0, OP_LW,  32'h100, 0, 32'h3333_3333, 1,        0, 0, 4'h0, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, OP_LH,  32'h100, 0, 32'h7FFF_0000, 1,        1, 0, 4'hF, 0, 1, 32'h0000_7FFF, 1, 0);

    // Reset with a memory op presented: no request, no stall, outputs cleared.
    rst = 1'b1; ack = 1'b0;
    drive(1, OP_LW, 32'h100, 0, 1, 32'hDEAD_BEEF);
    tick();
    tick();
    chk1("rst_req", req_a, 1'b0);
    chk1("rst_stall", stall_a, 1'b0);
    chk1("rst_rw", rw_a, 1'b0);
    chk("rst_wd", wd_a, 32'h0);
    chk("rst_pc", pco_a, 32'h0);
    chk1("rst_aerr", aerr_a, 1'b0);
    chk1("rst_berr", berr_a, 1'b0);
    rst = 1'b0;
    drive(0, 6'b000000, 0, 0, 0, 0);
    tick();

    // Single-cycle transactions with same-cycle ack.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].rw_in, vecs[i].rdata);
      ack = 1'b1;
      #1;
      chk1($sformatf("v%0d_req", i), req_a, vecs[i].exp_req);
      chk1($sformatf("v%0d_stall", i), stall_a, 1'b0);
      if (vecs[i].exp_req) begin
        chk($sformatf("v%0d_addr", i), addr_a, vecs[i].addr & 32'hFFFF_FFFC);
        chk($sformatf("v%0d_be", i), {28'd0, be_a}, {28'd0, vecs[i].exp_be});
        chk1($sformatf("v%0d_we", i), we_a, vecs[i].exp_we);
        if (vecs[i].exp_we) chk($sformatf("v%0d_wdata", i), wdat_a, vecs[i].exp_wdat);
      end
      tick();
      chk1($sformatf("v%0d_rw", i), rw_a, vecs[i].exp_rw);
      chk1($sformatf("v%0d_aerr", i), aerr_a, vecs[i].exp_ae);
      if (vecs[i].chk_wd) chk($sformatf("v%0d_wd", i), wd_a, vecs[i].exp_wd);
    end
    ack = 1'b0;
    drive(0, 6'b000000, 0, 0, 0, 0);
    tick();

    // LW with ack three cycles after issue.
    drive(1, OP_LW, 32'h100, 0, 1, 32'hDEAD_BEEF);
    wr = 5'd7;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk1($sformatf("lw3_stall_c%0d", c), stall_a, 1'b1);
      chk1($sformatf("lw3_req_c%0d", c), req_a, 1'b1);
      tick();
      chk1($sformatf("lw3_bubble_c%0d", c), rw_a, 1'b0);
    end
    ack = 1'b1;
    #1;
    chk1("lw3_stall_ack", stall_a, 1'b0);
    tick();
    ack = 1'b0;
    drive(0, 6'b000000, 0, 0, 0, 0);
    chk1("lw3_rw", rw_a, 1'b1);
    chk("lw3_wd", wd_a, 32'hDEAD_BEEF);
    chk("lw3_wr", {27'd0, wr_a}, 32'd7);
    chk("lw3_pc", pco_a, 32'h4000_0100);
    #1;
    chk1("lw3_idle_req", req_a, 1'b0);
    tick();

    // No ack: timeout after four WAIT cycles.
    drive(1, OP_LW, 32'h104, 0, 1, 32'h5555_5555);
    nst = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (!stall_a) break;
      nst++;
      tick();
    end
    chk("to_stall_cycles", nst, 32'd4);
    chk1("to_req_last_wait", req_a, 1'b1);
    tick();
    drive(0, 6'b000000, 0, 0, 0, 0);
    #1;
    chk1("to_berr", berr_a, 1'b1);
    chk1("to_rw", rw_a, 1'b0);
    chk1("to_req_dropped", req_a, 1'b0);
    tick();
    chk1("to_berr_pulse", berr_a, 1'b0);

    // Ack arriving on the fourth WAIT cycle wins over timeout.
    drive(1, OP_LW, 32'h108, 0, 1, 32'h0BAD_F00D);
    for (int c = 0; c < 4; c++) tick();
    ack = 1'b1;
    #1;
    chk1("ack4_stall", stall_a, 1'b0);
    tick();
    ack = 1'b0;
    drive(0, 6'b000000, 0, 0, 0, 0);
    chk1("ack4_berr", berr_a, 1'b0);
    chk1("ack4_rw", rw_a, 1'b1);
    chk("ack4_wd", wd_a, 32'h0BAD_F00D);
    tick();
    chk1("ack4_berr_next", berr_a, 1'b0);

    // LL then SC to the same word succeeds; a second SC fails.
    ack = 1'b1;
    drive(1, OP_LL, 32'h300, 0, 1, 32'h1111_2222);
    tick();
    chk("ll_wd", wd_a, 32'h1111_2222);
    drive(1, OP_SC, 32'h300, 32'h5, 1, 0);
    #1;
    chk1("sc_ok_req", req_a, 1'b1);
    chk1("sc_ok_we", we_a, 1'b1);
    tick();
    chk("sc_ok_wd", wd_a, 32'd1);
    ack = 1'b0;
    drive(1, OP_SC, 32'h300, 32'h6, 1, 0);
    #1;
    chk1("sc_again_req", req_a, 1'b0);
    tick();
    chk("sc_again_wd", wd_a, 32'd0);
    chk1("sc_again_rw", rw_a, 1'b1);

    // LL, SW to the linked word, then SC fails.
    ack = 1'b1;
    drive(1, OP_LL, 32'h300, 0, 1, 32'h0);
    tick();
    drive(1, OP_SW, 32'h300, 32'h9, 0, 0);
    tick();
    ack = 1'b0;
    drive(1, OP_SC, 32'h300, 32'h7, 1, 0);
    #1;
    chk1("sc_after_sw_req", req_a, 1'b0);
    tick();
    chk("sc_after_sw_wd", wd_a, 32'd0);

    // LL then SC to a different word fails.
    ack = 1'b1;
    drive(1, OP_LL, 32'h300, 0, 1, 32'h0);
    tick();
    ack = 1'b0;
    drive(1, OP_SC, 32'h304, 32'h7, 1, 0);
    #1;
    chk1("sc_other_req", req_a, 1'b0);
    tick();
    chk("sc_other_wd", wd_a, 32'd0);

    // Little-endian instance without LL/SC.
    rst = 1'b1;
    drive(0, 6'b000000, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    ack = 1'b1;
    drive(1, OP_LB, 32'h103, 0, 1, 32'h0);
    rd_b = 32'hF000_0000;
    tick();
    chk("le_lb_wd", wd_b, 32'hFFFF_FFF0);
    drive(1, OP_SB, 32'h101, 32'h0000_00C3, 0, 0);
    #1;
    chk("le_sb_be", {28'd0, be_b}, 32'h2);
    chk("le_sb_wdata", wdat_b, 32'hC3C3_C3C3);
    tick();
    drive(1, OP_SC, 32'h300, 32'h77, 1, 0);
    #1;
    chk1("le_sc_req", req_b, 1'b1);
    chk1("le_sc_we", we_b, 1'b1);
    tick();
    chk("le_sc_wd", wd_b, 32'd1);

    // Reset while waiting abandons the access.
    ack = 1'b0;
    drive(1, OP_LW, 32'h10C, 0, 1, 32'h1234_5678);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk1("rstw_req", req_a, 1'b0);
    chk1("rstw_stall", stall_a, 1'b0);
    tick();
    rst = 1'b0;
    drive(0, 6'b000000, 0, 0, 0, 0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (berr_a || rw_a || req_a) seen = 1'b1;
      tick();
    end
    chk1("rstw_no_wb_or_err", seen, 1'b0);

    // Stray ack while idle is ignored.
    ack = 1'b1;
    #1;
    chk1("stray_req", req_a, 1'b0);
    chk1("stray_stall", stall_a, 1'b0);
    tick();
    chk1("stray_rw", rw_a, 1'b0);
    ack = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_handshake.md
MEM_HANDSHAKE -- requirements
Module: mem_handshake

Interface
REQ-001 Parameters SHALL be: BIG_ENDIAN, 1, byte offset 0 maps to data bits 31:24 (0 maps offset 0 to bits 7:0); TIMEOUT, 255, maximum WAIT cycles before bus error (8-bit counter); LLSC_EN, 1, enables the LL/SC link register.
REQ-002 There SHALL be one clock and reset is synchronous and active-high; ports CLK (in, 1, clock) and RESET (in, 1, synchronous active-high reset) come first.
REQ-003 Pipeline inputs SHALL be: Valid_IN (1), Instr1_PC_IN (32, debug), ALU_result1_IN (32, address or result), WriteRegister1_IN (5), MemWriteData1_IN (32, store data), RegWrite1_IN (1), ALU_Control1_IN (6, op code), MemRead1_IN (1), MemWrite1_IN (1).
REQ-004 Pipeline outputs SHALL be: WriteRegister1_OUT (5), RegWrite1_OUT (1), WriteData1_OUT (32), Instr1_PC_OUT (32), Stall_OUT (1, upstream hold), AddrErr_OUT (1), BusErr_OUT (1).
REQ-005 Memory-side ports SHALL be: dm_req_OUT (1), dm_we_OUT (1), dm_addr_OUT (32, word-aligned), dm_be_OUT (4, byte enables), dm_wdata_OUT (32), dm_ack_IN (1), dm_rdata_IN (32).

Function
REQ-006 Op codes SHALL be: LB 100001, LH 101011, LBU 101010, LHU 101100, LW 111101, LL 101000, SB 101111, SH 110000, SW 110001, SC 110110; any other code is a non-memory op.
REQ-007 The FSM SHALL have states IDLE and WAIT; IDLE -> WAIT on an issued request without same-cycle dm_ack_IN; WAIT -> IDLE on dm_ack_IN or timeout.
REQ-008 A non-memory op with Valid_IN high SHALL be registered to the outputs in 1 cycle: WriteData1_OUT = ALU_result1_IN, with no request issued.
REQ-009 An aligned memory op SHALL assert dm_req_OUT combinationally in its first cycle and hold it, with address, enables and data stable, until dm_ack_IN; zero-wait completion on a same-cycle ack is legal.
REQ-010 Stall_OUT SHALL equal (valid memory op issuing or in WAIT) AND NOT dm_ack_IN; upstream holds all inputs stable while Stall_OUT is high.
REQ-011 Writeback outputs SHALL update on the ack cycle edge; while stalled they SHALL hold a bubble (RegWrite1_OUT = 0).
REQ-012 dm_addr_OUT SHALL be {ALU_result1_IN[31:2], 2'b00}; dm_we_OUT = 1 for stores.
REQ-013 Byte lane k (address offset k) SHALL map to be bit 3-k and bits [31-8k:24-8k] when BIG_ENDIAN = 1, and to be bit k and bits [8k+7:8k] when BIG_ENDIAN = 0.
REQ-014 SB SHALL replicate the byte 4x and SH the halfword 2x in dm_wdata_OUT; SW/SC pass data unchanged; be SHALL be 1 lane for SB, 2 lanes for SH, 4'b1111 for SW/SC.
REQ-015 Loads SHALL extract the addressed lane(s) from dm_rdata_IN; LB/LH sign-extend, LBU/LHU zero-extend, LW/LL pass the full word; loads read with be = 4'b1111.
REQ-016 Misalignment (LH/LHU/SH with addr[0] = 1; LW/LL/SW/SC with addr[1:0] != 0) SHALL issue no request; the next cycle gives AddrErr_OUT = 1 for 1 cycle with RegWrite1_OUT = 0.
REQ-017 The timeout counter SHALL clear on issue and increment each WAIT cycle; on reaching TIMEOUT without ack, dm_req_OUT drops, BusErr_OUT pulses 1 cycle, RegWrite1_OUT = 0, and Stall_OUT is released.
REQ-018 Ack and timeout in the same cycle SHALL resolve as ack (normal completion, no BusErr).
REQ-019 Link register (LLSC_EN = 1): a completed LL SHALL set link_valid and link_addr = addr[31:2].
REQ-020 SC with link_valid and a matching address SHALL issue the write and return WriteData1_OUT = 1; otherwise it issues no request and returns 0 next cycle; SC always clears link_valid.
REQ-021 Any completed store to the linked word SHALL clear link_valid; with LLSC_EN = 0, SC behaves as SW and returns 1.
REQ-022 dm_ack_IN while IDLE with no request SHALL be ignored.

Reset
REQ-023 With RESET high at a CLK edge, every registered output SHALL be 0, the state IDLE, the counter 0 and link_valid 0; dm_req_OUT and Stall_OUT SHALL be 0 while RESET is high.
REQ-024 Reset during WAIT SHALL abandon the access: no writeback and no error pulse.

Structure
REQ-025 A shared package mem_pkg SHALL hold the op-code constants, the state enum and the byte-enable width.
REQ-026 Lane extraction, store replication and byte-enable generation SHALL be one combinational sub-module, mem_lane_align, parametrised by BIG_ENDIAN.

Verification
REQ-027 LW at 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> Stall_OUT high 3 cycles, WriteData1_OUT = 0xDEADBEEF, RegWrite1_OUT = 1.
REQ-028 LB at 0x103, rdata 0x000000F0, BIG_ENDIAN = 1 -> WriteData1_OUT = 0xFFFFFFF0; with BIG_ENDIAN = 0 and rdata 0xF0000000 -> same result.
REQ-029 SH at 0x202, data 0x1234ABCD, BIG_ENDIAN = 1 -> dm_be_OUT = 4'b0011, dm_wdata_OUT = 0xABCDABCD, dm_addr_OUT = 0x200.
REQ-030 LW at 0x101 -> no dm_req_OUT, AddrErr_OUT pulse 1 cycle, RegWrite1_OUT = 0.
REQ-031 No ack for TIMEOUT = 4 -> BusErr_OUT pulse after 4 WAIT cycles, req dropped; in a second run, ack on cycle 4 -> no BusErr.
REQ-032 LL at 0x300 then SC at 0x300 -> write issued, result 1; LL 0x300, SW 0x300, then SC 0x300 -> no request, result 0.
